periph_bus_arbiter: RTL
=======================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, meaning cycles sys_r is held before sys_r_line is sampled (legal 1..15).
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1 each  requester N transaction request.
- m0_we, m1_we  in  1 each  1 = write, 0 = read.
- m0_addr, m1_addr  in  32 each  target peripheral address.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32 each  read data; valid when ack is high.
- sys_w_addr, sys_r_addr  out  32 each  peripheral bus write/read address.
- sys_w_line  out  32  peripheral bus write data.
- sys_r_line  in  32  peripheral bus read data.
- sys_w, sys_r  out  1 each  peripheral bus write/read strobes.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, WR, RD and ACK.
REQ-004 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-005 In IDLE with both reqs high, the requester other than last_grant SHALL be granted (round-robin).
REQ-006 On grant, the block SHALL register the winner's we, addr and wdata and the grant index.
- Next state: WR if we=1, otherwise RD.
REQ-007 In WR the block SHALL drive sys_w=1, sys_w_addr=addr and sys_w_line=wdata for exactly one cycle, then go to ACK.
REQ-008 In RD the block SHALL drive sys_r=1 and sys_r_addr=addr for exactly RD_LAT consecutive cycles, counted by a 4-bit counter.
- On the last RD cycle it SHALL capture sys_r_line into the granted requester's rdata register, then go to ACK.
REQ-009 In ACK the block SHALL:
- pulse the granted requester's ack for one cycle;
- set last_grant to the granted index;
- return to IDLE.
REQ-010 Write transaction latency SHALL be 3 cycles, from the grant edge to the ack cycle inclusive (IDLE, WR, ACK). Read transaction latency SHALL be RD_LAT+2 cycles.
REQ-011 Requesters SHALL hold req, we, addr and wdata stable until ack; the block ignores changes to them after grant.
REQ-012 A req still high in the cycle after ack SHALL be treated as a new request. Back-to-back requests SHALL have a minimum issue spacing of one IDLE cycle.
REQ-013 Outside WR, sys_w SHALL be 0 and sys_w_addr/sys_w_line SHALL be 0. Outside RD, sys_r SHALL be 0 and sys_r_addr SHALL be 0.
REQ-014 sys_w and sys_r SHALL never be high in the same cycle, and at most one ack SHALL be high per cycle.
REQ-015 rdata SHALL hold its last captured value until the next read for that requester. A write SHALL NOT modify rdata.
REQ-016 The non-granted requester's req SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-017 When rst=0, the block SHALL asynchronously set the following, and leave them so while rst=0:
- FSM to IDLE and counter to 0;
- last_grant to 1, so m0 wins the first tie;
- sys_w, sys_r, both addresses and sys_w_line to 0;
- both acks, both rdata and busy to 0.
REQ-018 Reset asserted mid-transaction SHALL abort it: strobes drop immediately, no ack is issued, and no rdata is updated.
REQ-019 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single write: m0_req=1, we=1, addr=0xA, wdata=0x55 -> sys_w=1, sys_w_addr=0xA, sys_w_line=0x55 for one cycle; m0_ack one cycle later; m1_ack stays 0.
- Read, RD_LAT=2: m1 reads addr=0xB, peripheral drives sys_r_line=0xDEADBEEF -> sys_r high 2 cycles; m1_ack with m1_rdata=0xDEADBEEF.
- Simultaneous after reset, both holding req -> grant order m0, m1, m0, m1; every ack pulse is exactly one cycle.
- Reset in RD: rst=0 during the first RD cycle -> sys_r=0 immediately; no ack; rdata=0; busy=0.
- Strobe exclusivity over 1000 random requests: sys_w&sys_r never both high; acks never both high; every request acked exactly once.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter bridging m0/m1 transactions onto a single
// peripheral bus with separate write and read strobes.
module periph_bus_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] sys_w_addr,
  output logic [31:0] sys_r_addr,
  output logic [31:0] sys_w_line,
  input  logic [31:0] sys_r_line,
  output logic        sys_w,
  output logic        sys_r,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_gnt;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_sys_w;
  logic        r_sys_r;
  logic [31:0] r_sys_w_addr;
  logic [31:0] r_sys_r_addr;
  logic [31:0] r_sys_w_line;
  logic        r_busy;

  logic        w_any;
  logic        w_gnt;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // On a tie the requester that did not win last time is chosen.
  assign w_any   = m0_req | m1_req;
  assign w_gnt   = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_we    = w_gnt ? m1_we    : m0_we;
  assign w_addr  = w_gnt ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt ? m1_wdata : m0_wdata;

  // NOTE: every register below is state, so it is assigned with <= only;
  // blocking assignments here would create ordering-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      // NOTE: the read-data holding registers are reset too, so an aborted
      // or never-issued read always presents zero rather than stale data.
      r_m0_rdata   <= 32'd0;
      r_m1_rdata   <= 32'd0;
      r_sys_w      <= 1'b0;
      r_sys_r      <= 1'b0;
      r_sys_w_addr <= 32'd0;
      r_sys_r_addr <= 32'd0;
      r_sys_w_line <= 32'd0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The bus-side address/data registers double as the latched
          // transaction, so later changes on the requester ports are ignored.
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_busy <= 1'b1;
            r_cnt  <= 4'd0;
            if (w_we) begin
              r_state      <= WR;
              r_sys_w      <= 1'b1;
              r_sys_w_addr <= w_addr;
              r_sys_w_line <= w_wdata;
            end else begin
              r_state      <= RD;
              r_sys_r      <= 1'b1;
              r_sys_r_addr <= w_addr;
            end
          end
        end
        WR: begin
          r_sys_w      <= 1'b0;
          r_sys_w_addr <= 32'd0;
          r_sys_w_line <= 32'd0;
          r_m0_ack     <= ~r_gnt;
          r_m1_ack     <= r_gnt;
          r_state      <= ACK;
        end
        RD: begin
          if (r_cnt == LAST_CNT) begin
            if (r_gnt) r_m1_rdata <= sys_r_line;
            else       r_m0_rdata <= sys_r_line;
            r_sys_r      <= 1'b0;
            r_sys_r_addr <= 32'd0;
            r_m0_ack     <= ~r_gnt;
            r_m1_ack     <= r_gnt;
            r_state      <= ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ACK: begin
          r_m0_ack     <= 1'b0;
          r_m1_ack     <= 1'b0;
          r_last_grant <= r_gnt;
          r_busy       <= 1'b0;
          r_cnt        <= 4'd0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;
  assign sys_w      = r_sys_w;
  assign sys_r      = r_sys_r;
  assign sys_w_addr = r_sys_w_addr;
  assign sys_r_addr = r_sys_r_addr;
  assign sys_w_line = r_sys_w_line;
  assign busy       = r_busy;

endmodule
